vga_timing_core: RTL and testbench

Parametrised VGA timing and pixel pipeline for the display path. It generates horizontal/vertical counters for any mode, drives framebuffer read addresses, and realigns HS/VS/DE with read data returning RD_LAT pixel steps later. It blanks colour outside the active area and issues line/frame strobes for the frame-swap logic. It sits between the pixel-rate framebuffer and the VGA pins.

---
 rtl/vga_timing_core.sv | 218 +++++++++++++++++++++
 tb/tb_vga_timing_core.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/vga_timing_core.sv
`default_nettype none
// ============================================================================
//  Module   : vga_timing_core
//  Purpose  : Parametrised VGA timing generator and pixel pipeline. Produces
//             horizontal/vertical counters, framebuffer read addresses, and
//             HS/VS/DE/COLOUR_OUT realigned with read data that returns
//             RD_LAT pixel steps after the address. Colour is blanked outside
//             the active area. Line/frame strobes feed the frame-swap logic.
//  Ports    : i_clk        system clock
//             i_rst_n      asynchronous active-low reset
//             i_pix_en     pixel-step enable
//             i_blank      forces o_colour_out to 0 (sampled at output stage)
//             i_colour_in  framebuffer read data
//             o_addrh      pixel column address (0 outside active area)
//             o_addrv      pixel row address (0 outside active area)
//             o_addr_valid address lies inside the active area
//             o_colour_out pixel to the DAC
//             o_hs, o_vs   sync outputs (polarity set by HS_POL / VS_POL)
//             o_de         active video, aligned with o_colour_out
//             o_line_end   single-clk strobe on the h_cnt wrap edge
//             o_frame_end  single-clk strobe on the frame wrap edge
//  Revision : 1.0 - initial release
// ============================================================================
module vga_timing_core #(
  parameter int   H_ACTIVE = 640,
  parameter int   H_FP     = 16,
  parameter int   H_SYNC   = 96,
  parameter int   H_BP     = 48,
  parameter int   V_ACTIVE = 480,
  parameter int   V_FP     = 10,
  parameter int   V_SYNC   = 2,
  parameter int   V_BP     = 33,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0,
  parameter int   COLOUR_W = 8,
  parameter int   RD_LAT   = 1,
  parameter int   X_W      = 10,
  parameter int   Y_W      = 10
) (
  input  logic                i_clk,
  input  logic                i_rst_n,
  input  logic                i_pix_en,
  input  logic                i_blank,
  input  logic [COLOUR_W-1:0] i_colour_in,
  output logic [X_W-1:0]      o_addrh,
  output logic [Y_W-1:0]      o_addrv,
  output logic                o_addr_valid,
  output logic [COLOUR_W-1:0] o_colour_out,
  output logic                o_hs,
  output logic                o_vs,
  output logic                o_de,
  output logic                o_line_end,
  output logic                o_frame_end
);

  localparam int c_H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int c_V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  localparam logic [X_W-1:0] c_H_LAST     = X_W'(c_H_TOTAL - 1);
  localparam logic [X_W-1:0] c_H_ACT      = X_W'(H_ACTIVE);
  localparam logic [X_W-1:0] c_HS_FIRST   = X_W'(H_ACTIVE + H_FP);
  localparam logic [X_W-1:0] c_HS_LAST    = X_W'(H_ACTIVE + H_FP + H_SYNC - 1);
  localparam logic [Y_W-1:0] c_V_LAST     = Y_W'(c_V_TOTAL - 1);
  localparam logic [Y_W-1:0] c_V_ACT      = Y_W'(V_ACTIVE);
  localparam logic [Y_W-1:0] c_VS_FIRST   = Y_W'(V_ACTIVE + V_FP);
  localparam logic [Y_W-1:0] c_VS_LAST    = Y_W'(V_ACTIVE + V_FP + V_SYNC - 1);

  // Elaboration-time legality checks.
  generate
    if (RD_LAT < 0 || RD_LAT > 4) begin : g_bad_rd_lat
      $error("vga_timing_core: RD_LAT must be in 0..4");
    end
    if (longint'(c_H_TOTAL) > (longint'(1) << X_W)) begin : g_bad_x_w
      $error("vga_timing_core: X_W too narrow for H_TOTAL-1");
    end
    if (longint'(c_V_TOTAL) > (longint'(1) << Y_W)) begin : g_bad_y_w
      $error("vga_timing_core: Y_W too narrow for V_TOTAL-1");
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Stage 0: counters and (unpipelined) strobes
  // --------------------------------------------------------------------------
  logic [X_W-1:0] r_h_cnt;
  logic [Y_W-1:0] r_v_cnt;
  logic           r_line_end;
  logic           r_frame_end;
  logic           w_h_wrap;
  logic           w_v_wrap;

  assign w_h_wrap = (r_h_cnt == c_H_LAST);
  assign w_v_wrap = (r_v_cnt == c_V_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_h_cnt     <= '0;
      r_v_cnt     <= '0;
      r_line_end  <= 1'b0;
      r_frame_end <= 1'b0;
    end else begin
      // Strobes are the only state that does not hold across disabled clocks.
      r_line_end  <= 1'b0;
      r_frame_end <= 1'b0;
      if (i_pix_en) begin
        if (w_h_wrap) begin
          r_h_cnt    <= '0;
          r_line_end <= 1'b1;
          if (w_v_wrap) begin
            r_v_cnt     <= '0;
            r_frame_end <= 1'b1;
          end else begin
            r_v_cnt <= r_v_cnt + 1'b1;
          end
        end else begin
          r_h_cnt <= r_h_cnt + 1'b1;
        end
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage 1: addresses and raw timing flags
  // --------------------------------------------------------------------------
  logic           w_active;
  logic           w_sync_h;
  logic           w_sync_v;
  logic [X_W-1:0] r_addrh;
  logic [Y_W-1:0] r_addrv;
  logic           r_addr_valid;
  logic           r_s1_sync_h;
  logic           r_s1_sync_v;

  assign w_active = (r_h_cnt < c_H_ACT) && (r_v_cnt < c_V_ACT);
  assign w_sync_h = (r_h_cnt >= c_HS_FIRST) && (r_h_cnt <= c_HS_LAST);
  assign w_sync_v = (r_v_cnt >= c_VS_FIRST) && (r_v_cnt <= c_VS_LAST);

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_addrh      <= '0;
      r_addrv      <= '0;
      r_addr_valid <= 1'b0;
      r_s1_sync_h  <= 1'b0;
      r_s1_sync_v  <= 1'b0;
    end else if (i_pix_en) begin
      r_addrh      <= w_active ? r_h_cnt : '0;
      r_addrv      <= w_active ? r_v_cnt : '0;
      r_addr_valid <= w_active;
      r_s1_sync_h  <= w_sync_h;
      r_s1_sync_v  <= w_sync_v;
    end
  end

  // --------------------------------------------------------------------------
  // Delay line: {sync_h, sync_v, active} delayed RD_LAT steps so the flags
  // meet the framebuffer data that returns for the same address.
  // --------------------------------------------------------------------------
  logic [2:0] w_s1;
  logic [2:0] w_dly;

  assign w_s1 = {r_s1_sync_h, r_s1_sync_v, r_addr_valid};

  generate
    if (RD_LAT == 0) begin : g_no_dly
      assign w_dly = w_s1;
    end else begin : g_dly
      logic [2:0] r_tap [RD_LAT];

      always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
          for (int i = 0; i < RD_LAT; i++) begin
            r_tap[i] <= '0;
          end
        end else if (i_pix_en) begin
          r_tap[0] <= w_s1;
          for (int i = 1; i < RD_LAT; i++) begin
            r_tap[i] <= r_tap[i-1];
          end
        end
      end

      assign w_dly = r_tap[RD_LAT-1];
    end
  endgenerate

  // --------------------------------------------------------------------------
  // Output stage
  // --------------------------------------------------------------------------
  logic                r_hs;
  logic                r_vs;
  logic                r_de;
  logic [COLOUR_W-1:0] r_colour;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_hs     <= ~HS_POL;
      r_vs     <= ~VS_POL;
      r_de     <= 1'b0;
      r_colour <= '0;
    end else if (i_pix_en) begin
      r_hs     <= w_dly[2] ? HS_POL : ~HS_POL;
      r_vs     <= w_dly[1] ? VS_POL : ~VS_POL;
      r_de     <= w_dly[0];
      r_colour <= (w_dly[0] && !i_blank) ? i_colour_in : '0;
    end
  end

  assign o_addrh      = r_addrh;
  assign o_addrv      = r_addrv;
  assign o_addr_valid = r_addr_valid;
  assign o_colour_out = r_colour;
  assign o_hs         = r_hs;
  assign o_vs         = r_vs;
  assign o_de         = r_de;
  assign o_line_end   = r_line_end;
  assign o_frame_end  = r_frame_end;

endmodule
`default_nettype wire

// File: tb/tb_vga_timing_core.sv
`default_nettype none
// ============================================================================
//  Module   : tb_vga_timing_core
//  Purpose  : Self-checking bench for vga_timing_core. Two instances share
//             stimulus in a reduced video mode: one active-low sync with
//             RD_LAT=3 fed by a delayed bench memory, one active-high sync
//             with RD_LAT=0 fed combinationally. A counter model pushes the
//             expected pixel for every step into per-instance queues which
//             are popped when that pixel reaches the outputs.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_vga_timing_core;

  localparam int HA  = 16;
  localparam int HFP = 4;
  localparam int HSW = 6;
  localparam int HBP = 5;
  localparam int VA  = 6;
  localparam int VFP = 2;
  localparam int VSW = 2;
  localparam int VBP = 3;
  localparam int HT  = HA + HFP + HSW + HBP;  // 31
  localparam int VT  = VA + VFP + VSW + VBP;  // 13
  localparam int LAT1 = 3;

  logic       clk;
  logic       rst_n;
  logic       pix_en;
  logic       blank;
  logic [7:0] col_in1;
  logic [7:0] col_in2;

  logic [5:0] o_addrh1, o_addrh2;
  logic [3:0] o_addrv1, o_addrv2;
  logic       o_av1, o_av2;
  logic [7:0] o_col1, o_col2;
  logic       o_hs1, o_hs2, o_vs1, o_vs2, o_de1, o_de2;
  logic       o_le1, o_le2, o_fe1, o_fe2;

  vga_timing_core #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b0), .VS_POL(1'b0), .COLOUR_W(8), .RD_LAT(LAT1),
    .X_W(6), .Y_W(4)
  ) u_dut_lo (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .i_blank(blank),
    .i_colour_in(col_in1),
    .o_addrh(o_addrh1), .o_addrv(o_addrv1), .o_addr_valid(o_av1),
    .o_colour_out(o_col1), .o_hs(o_hs1), .o_vs(o_vs1), .o_de(o_de1),
    .o_line_end(o_le1), .o_frame_end(o_fe1)
  );

  vga_timing_core #(
    .H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HSW), .H_BP(HBP),
    .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VSW), .V_BP(VBP),
    .HS_POL(1'b1), .VS_POL(1'b1), .COLOUR_W(8), .RD_LAT(0),
    .X_W(6), .Y_W(4)
  ) u_dut_hi (
    .i_clk(clk), .i_rst_n(rst_n), .i_pix_en(pix_en), .i_blank(blank),
    .i_colour_in(col_in2),
    .o_addrh(o_addrh2), .o_addrv(o_addrv2), .o_addr_valid(o_av2),
    .o_colour_out(o_col2), .o_hs(o_hs2), .o_vs(o_vs2), .o_de(o_de2),
    .o_line_end(o_le2), .o_frame_end(o_fe2)
  );

  // Combinational framebuffer for the zero-latency instance.
  assign col_in2 = {o_addrv2[1:0], o_addrh2};

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic       sh;
    logic       sv;
    logic       act;
    logic [7:0] col;
  } ent_t;

  ent_t q1[$];
  ent_t q2[$];
  logic [7:0] mem_pipe [LAT1+1];

  int n_vec;
  int n_err;

  // Model state
  int         mh, mv;
  logic       e_le, e_fe, e_av;
  logic [5:0] e_ah;
  logic [3:0] e_avv;
  logic       x_hs1, x_vs1, x_de1, x_hs2, x_vs2, x_de2;
  logic [7:0] x_col1, x_col2;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h at t=%0t", tag, obs, exp, $time);
    end
  endtask

  task automatic chk_all();
    chk("line_end",   32'(o_le1),    32'(e_le));
    chk("frame_end",  32'(o_fe1),    32'(e_fe));
    chk("addr_valid", 32'(o_av1),    32'(e_av));
    chk("addrh",      32'(o_addrh1), 32'(e_ah));
    chk("addrv",      32'(o_addrv1), 32'(e_avv));
    chk("hs_lo",      32'(o_hs1),    32'(x_hs1));
    chk("vs_lo",      32'(o_vs1),    32'(x_vs1));
    chk("de_lo",      32'(o_de1),    32'(x_de1));
    chk("col_lo",     32'(o_col1),   32'(x_col1));
    chk("line_end2",  32'(o_le2),    32'(e_le));
    chk("frame_end2", 32'(o_fe2),    32'(e_fe));
    chk("addrh2",     32'(o_addrh2), 32'(e_ah));
    chk("hs_hi",      32'(o_hs2),    32'(x_hs2));
    chk("vs_hi",      32'(o_vs2),    32'(x_vs2));
    chk("de_hi",      32'(o_de2),    32'(x_de2));
    chk("col_hi",     32'(o_col2),   32'(x_col2));
  endtask

  // Put the model into its post-reset state; the queues are pre-loaded with
  // the idle pixels the cleared pipeline emits before real data arrives.
  task automatic model_reset();
    ent_t idle;
    idle = '0;
    mh = 0; mv = 0;
    e_le = 1'b0; e_fe = 1'b0; e_av = 1'b0; e_ah = '0; e_avv = '0;
    q1.delete(); q2.delete();
    for (int i = 0; i < LAT1 + 1; i++) q1.push_back(idle);
    q2.push_back(idle);
    x_hs1 = 1'b1; x_vs1 = 1'b1; x_de1 = 1'b0; x_col1 = '0;
    x_hs2 = 1'b0; x_vs2 = 1'b0; x_de2 = 1'b0; x_col2 = '0;
  endtask

  // One CLK with the given enable and blank, then compare every output.
  task automatic step(input logic pe, input logic bl);
    int   hb, vb;
    ent_t ent, e1, e2;
    pix_en = pe;
    blank  = bl;
    @(posedge clk);
    #1;
    if (pe) begin
      hb = mh; vb = mv;
      e_le = (hb == HT - 1);
      e_fe = e_le && (vb == VT - 1);
      if (e_le) begin
        mh = 0;
        mv = (vb == VT - 1) ? 0 : vb + 1;
      end else begin
        mh = hb + 1;
      end
      e_av  = (hb < HA) && (vb < VA);
      e_ah  = e_av ? 6'(hb) : 6'd0;
      e_avv = e_av ? 4'(vb) : 4'd0;
      ent.sh  = (hb >= HA + HFP) && (hb < HA + HFP + HSW);
      ent.sv  = (vb >= VA + VFP) && (vb < VA + VFP + VSW);
      ent.act = e_av;
      ent.col = 8'((vb % 4) * 64 + hb);
      q1.push_back(ent);
      q2.push_back(ent);
      e1 = q1.pop_front();
      e2 = q2.pop_front();
      x_hs1 = ~e1.sh; x_vs1 = ~e1.sv; x_de1 = e1.act;
      x_col1 = (e1.act && !bl) ? e1.col : 8'd0;
      x_hs2 = e2.sh;  x_vs2 = e2.sv;  x_de2 = e2.act;
      x_col2 = (e2.act && !bl) ? e2.col : 8'd0;
      // Bench memory: data for the address shown now appears LAT1 steps later.
      for (int i = LAT1; i > 0; i--) mem_pipe[i] = mem_pipe[i-1];
      mem_pipe[0] = {o_addrv1[1:0], o_addrh1};
      col_in1 = mem_pipe[LAT1];
    end else begin
      e_le = 1'b0;
      e_fe = 1'b0;
    end
    chk_all();
  endtask

  task automatic chk_reset();
    chk("rst_addrh",  32'(o_addrh1), 32'd0);
    chk("rst_addrv",  32'(o_addrv1), 32'd0);
    chk("rst_av",     32'(o_av1),    32'd0);
    chk("rst_hs_lo",  32'(o_hs1),    32'd1);
    chk("rst_vs_lo",  32'(o_vs1),    32'd1);
    chk("rst_de",     32'(o_de1),    32'd0);
    chk("rst_col",    32'(o_col1),   32'd0);
    chk("rst_le",     32'(o_le1),    32'd0);
    chk("rst_fe",     32'(o_fe1),    32'd0);
    chk("rst_hs_hi",  32'(o_hs2),    32'd0);
    chk("rst_vs_hi",  32'(o_vs2),    32'd0);
    chk("rst_de_hi",  32'(o_de2),    32'd0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    n_vec = 0;
    n_err = 0;
    rst_n  = 1'b0;
    pix_en = 1'b0;
    blank  = 1'b0;
    col_in1 = '0;
    for (int i = 0; i <= LAT1; i++) mem_pipe[i] = '0;

    // Power-on reset
    repeat (3) @(posedge clk);
    #1;
    model_reset();
    chk_reset();
    rst_n = 1'b1;

    // Continuous pixel enable: a full frame and then some
    repeat (HT * VT + 50) step(1'b1, 1'b0);

    // BLANK for 10 steps inside an active line
    for (int i = 0; i < 2 * HT * VT && !(mh == 6 && mv == 2); i++) step(1'b1, 1'b0);
    repeat (10) step(1'b1, 1'b1);
    repeat (40) step(1'b1, 1'b0);

    // Enable every second clock: outputs hold, strobes stay one clock wide
    repeat (HT * VT * 2 + 100) begin
      step(1'b1, 1'b0);
      step(1'b0, 1'b0);
    end

    // Irregular enable and sporadic blank
    repeat (600) step(1'($urandom_range(0, 1)), 1'($urandom_range(0, 7) == 0));

    // Asynchronous reset in the middle of an active line
    for (int i = 0; i < 2 * HT * VT && !(mh == 10 && mv == 3); i++) step(1'b1, 1'b0);
    pix_en = 1'b1;
    #1;
    rst_n = 1'b0;
    #1;
    model_reset();
    chk_reset();
    repeat (5) begin
      @(posedge clk);
      #1;
      chk_reset();
    end
    rst_n = 1'b1;

    // First step restarts at (0,0); next frame strobe after exactly one frame
    repeat (HT * VT + 20) step(1'b1, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
